// File: rtl/ro_puf_compare_ctrl_if.sv
// Handshake and data bundle between the RO-PUF compare controller and its
// environment: start request, the two counter readbacks, counter control,
// challenge index and the response/status outputs.
// The controller sits on the slave modport; the driving side (counters,
// challenge mux, host) uses the master modport.
interface ro_puf_compare_ctrl_if;
    logic        start;
    logic [15:0] cntA;
    logic [15:0] cntB;
    logic        finA;
    logic        finB;
    logic        cntCe;
    logic        cntClr;
    logic [3:0]  sel;
    logic        busy;
    logic        done;
    logic [15:0] response;
    logic        err;

    modport master (
        output start, cntA, cntB, finA, finB,
        input  cntCe, cntClr, sel, busy, done, response, err
    );

    modport slave (
        input  start, cntA, cntB, finA, finB,
        output cntCe, cntClr, sel, busy, done, response, err
    );
endinterface

// File: rtl/ro_puf_compare_ctrl.sv
// Ring-oscillator PUF compare controller.
// For each challenge index SEL = 0..NUM_BITS-1 the controller clears the two
// counters, waits SETTLE_CYCLES for the oscillator mux to settle, lets the
// counters run until one of them reports finished, freezes them, captures
// both counts and stores (A > B) into RESPONSE[SEL].
// Optional feature macro: RO_PUF_TIMEOUT_EN adds a COUNT-state watchdog that
// forces the bit to 0 and raises a sticky ERR when no counter finishes within
// TIMEOUT_CYCLES. Without the macro ERR is tied low and COUNT waits forever.
module ro_puf_compare_ctrl #(
    parameter int NUM_BITS       = 16,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input logic                  clk_i,
    input logic                  clr_i,
    ro_puf_compare_ctrl_if.slave bus
);

    // Reject parameter values outside the supported ranges at elaboration
    if (NUM_BITS < 1 || NUM_BITS > 16 || SETTLE_CYCLES < 1 ||
        SETTLE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ro_puf_compare_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        COUNT,
        CAPTURE,
        COMPARE,
        FINISH
    } state_t;

    localparam logic [3:0] LastSel    = 4'(NUM_BITS - 1);
    localparam logic [7:0] LastSettle = 8'(SETTLE_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  sel_q;
    logic [15:0] response_q;
    logic        cntCe_q;
    logic        cntClr_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  settleCnt_q;
    logic [15:0] capA_q;
    logic [15:0] capB_q;

`ifdef RO_PUF_TIMEOUT_EN
    localparam int TimerWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimerWidth-1:0] LastTimer = TimerWidth'(TIMEOUT_CYCLES - 1);

    logic [TimerWidth-1:0] timer_q;
    logic                  timedOut_q;
    logic                  err_q;
`endif

    // Main sequencer: all outputs are registered and updated together with the state
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q     <= IDLE;
            sel_q       <= 4'd0;
            response_q  <= 16'd0;
            cntCe_q     <= 1'b0;
            cntClr_q    <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            settleCnt_q <= 8'd0;
            capA_q      <= 16'd0;
            capB_q      <= 16'd0;
`ifdef RO_PUF_TIMEOUT_EN
            timer_q     <= '0;
            timedOut_q  <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cntCe_q  <= 1'b0;
                    cntClr_q <= 1'b1;
                    done_q   <= 1'b0;
                    if (bus.start) begin
                        state_q    <= CLEAR;
                        sel_q      <= 4'd0;
                        response_q <= 16'd0;
                        busy_q     <= 1'b1;
`ifdef RO_PUF_TIMEOUT_EN
                        err_q      <= 1'b0;
`endif
                    end
                end
                CLEAR: begin
                    state_q     <= SETTLE;
                    cntClr_q    <= 1'b0;
                    settleCnt_q <= 8'd0;
                end
                SETTLE: begin
                    if (settleCnt_q == LastSettle) begin
                        state_q <= COUNT;
                        cntCe_q <= 1'b1;
`ifdef RO_PUF_TIMEOUT_EN
                        timer_q    <= '0;
                        timedOut_q <= 1'b0;
`endif
                    end else begin
                        settleCnt_q <= settleCnt_q + 8'd1;
                    end
                end
                COUNT: begin
                    if (bus.finA || bus.finB) begin
                        state_q <= CAPTURE;
                        cntCe_q <= 1'b0;
                    end
`ifdef RO_PUF_TIMEOUT_EN
                    else if (timer_q == LastTimer) begin
                        state_q    <= CAPTURE;
                        cntCe_q    <= 1'b0;
                        timedOut_q <= 1'b1;
                        err_q      <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
`endif
                end
                CAPTURE: begin
                    state_q <= COMPARE;
                    capA_q  <= bus.cntA;
                    capB_q  <= bus.cntB;
                end
                COMPARE: begin
`ifdef RO_PUF_TIMEOUT_EN
                    response_q[sel_q] <= (capA_q > capB_q) && !timedOut_q;
`else
                    response_q[sel_q] <= (capA_q > capB_q);
`endif
                    if (sel_q == LastSel) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= CLEAR;
                        sel_q    <= sel_q + 4'd1;
                        cntClr_q <= 1'b1;
                    end
                end
                FINISH: begin
                    state_q  <= IDLE;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    cntClr_q <= 1'b1;
                end
                default: begin
                    state_q  <= IDLE;
                    cntCe_q  <= 1'b0;
                    cntClr_q <= 1'b1;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cntCe    = cntCe_q;
    assign bus.cntClr   = cntClr_q;
    assign bus.sel      = sel_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.response = response_q;
`ifdef RO_PUF_TIMEOUT_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_ro_puf_compare_ctrl.sv
// Self-checking bench for ro_puf_compare_ctrl.
// A 16-bit instance exercises full randomized runs, ties, ignored START,
// reset in COUNT and the watchdog (RO_PUF_TIMEOUT_EN) or its absence.
// A 1-bit instance covers the short single-bit run and the unused upper bits.
module tb_ro_puf_compare_ctrl;

    localparam int BIG_BITS     = 16;
    localparam int BIG_SETTLE   = 3;
    localparam int SMALL_SETTLE = 2;
    localparam int RUN_LIMIT    = 3000;

    logic clk;
    logic clr;

    int checks;
    int errors;

    // Per-bit stimulus for one run of the big instance
    int          nCount[16];
    int          finMode[16];
    logic [15:0] aVals[16];
    logic [15:0] bVals[16];
    bit          injectStart;

    // Observations recorded by the run driver
    int          obsDoneCycle;
    int          obsDonePulses;
    int          obsCeAfterFin;
    int          obsBusyLow;
    int          obsBits;
    logic [3:0]  obsSel[16];
    bit          obsTimedOut;

    ro_puf_compare_ctrl_if bigIf ();
    ro_puf_compare_ctrl_if smallIf ();

    ro_puf_compare_ctrl #(
        .NUM_BITS      (BIG_BITS),
        .SETTLE_CYCLES (BIG_SETTLE),
        .TIMEOUT_CYCLES(64)
    ) dutBig (
        .clk_i(clk),
        .clr_i(clr),
        .bus  (bigIf)
    );

    ro_puf_compare_ctrl #(
        .NUM_BITS      (1),
        .SETTLE_CYCLES (SMALL_SETTLE),
        .TIMEOUT_CYCLES(64)
    ) dutSmall (
        .clk_i(clk),
        .clr_i(clr),
        .bus  (smallIf)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference response: bit i is set when counter A beat counter B
    function automatic logic [15:0] modelResponse(input int nBits);
        logic [15:0] r;
        r = 16'd0;
        for (int i = 0; i < nBits; i++) r[i] = (aVals[i] > bVals[i]);
        return r;
    endfunction

    // Reference DONE position: CLEAR + SETTLE + COUNT + CAPTURE + COMPARE per bit, then FINISH
    function automatic int modelDoneCycle(input int nBits, input int settle);
        int total;
        total = 1;
        for (int i = 0; i < nBits; i++) total += 1 + settle + nCount[i] + 2;
        return total;
    endfunction

    // Act as both counters for one full run of the big instance, recording what was seen
    task automatic applyStimulus(input int nBits);
        int cyc;
        int cnt;
        int bitIdx;
        bit finPending;
        obsDoneCycle  = -1;
        obsDonePulses = 0;
        obsCeAfterFin = 0;
        obsBusyLow    = 0;
        obsBits       = 0;
        obsTimedOut   = 1'b0;
        for (int i = 0; i < 16; i++) obsSel[i] = 4'hF;
        cnt        = 0;
        bitIdx     = 0;
        finPending = 1'b0;
        bigIf.start = 1'b1;
        @(negedge clk);
        bigIf.start = 1'b0;
        cyc = 1;
        while (cyc < RUN_LIMIT) begin
            if (finPending) begin
                if (bigIf.cntCe) obsCeAfterFin++;
                bigIf.finA = 1'b0;
                bigIf.finB = 1'b0;
                finPending = 1'b0;
            end
            if (injectStart && cyc == 3) bigIf.start = 1'b1;
            if (injectStart && cyc == 4) bigIf.start = 1'b0;
            if (obsDoneCycle < 0 && !bigIf.busy) obsBusyLow++;
            if (bigIf.done) begin
                obsDonePulses++;
                if (obsDoneCycle < 0) obsDoneCycle = cyc;
            end
            if (bigIf.cntCe && bitIdx < 16) begin
                cnt++;
                if (cnt == nCount[bitIdx]) begin
                    obsSel[bitIdx] = bigIf.sel;
                    bigIf.cntA = aVals[bitIdx];
                    bigIf.cntB = bVals[bitIdx];
                    bigIf.finA = (finMode[bitIdx] != 1);
                    bigIf.finB = (finMode[bitIdx] != 0);
                    finPending = 1'b1;
                    cnt = 0;
                    bitIdx++;
                end
            end
            if (obsDoneCycle >= 0 && cyc >= obsDoneCycle + 2) break;
            @(negedge clk);
            cyc++;
        end
        obsBits     = bitIdx;
        obsTimedOut = (cyc >= RUN_LIMIT);
    endtask

    // Compare a recorded big-instance run against the reference model
    task automatic checkOutput(input string name, input int nBits);
        logic [15:0] expResp;
        int          expDone;
        int          selBad;
        expResp = modelResponse(nBits);
        expDone = modelDoneCycle(nBits, BIG_SETTLE);
        selBad  = 0;
        for (int i = 0; i < nBits; i++) if (obsSel[i] !== 4'(i)) selBad++;

        checks++;
        if (obsTimedOut) begin
            errors++;
            $display("[TB] FAIL %s run_timeout: no DONE within %0d cycles", name, RUN_LIMIT);
        end
        checks++;
        if (bigIf.response !== expResp) begin
            errors++;
            $display("[TB] FAIL %s response: got %h expected %h", name, bigIf.response, expResp);
        end
        checks++;
        if (obsDoneCycle != expDone) begin
            errors++;
            $display("[TB] FAIL %s done_cycle: got %0d expected %0d", name, obsDoneCycle, expDone);
        end
        checks++;
        if (obsDonePulses != 1) begin
            errors++;
            $display("[TB] FAIL %s done_pulses: got %0d expected 1", name, obsDonePulses);
        end
        checks++;
        if (selBad != 0 || obsBits != nBits) begin
            errors++;
            $display("[TB] FAIL %s sel_order: %0d wrong of %0d, bits seen %0d expected %0d",
                     name, selBad, nBits, obsBits, nBits);
        end
        checks++;
        if (obsCeAfterFin != 0) begin
            errors++;
            $display("[TB] FAIL %s ce_after_fin: got %0d expected 0", name, obsCeAfterFin);
        end
        checks++;
        if (obsBusyLow != 0) begin
            errors++;
            $display("[TB] FAIL %s busy_during_run: low for %0d cycles expected 0", name, obsBusyLow);
        end
        checks++;
        if (bigIf.err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s err: got %b expected 0", name, bigIf.err);
        end
        checks++;
        if ({bigIf.busy, bigIf.done, bigIf.cntCe, bigIf.cntClr} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL %s idle_outputs: busy/done/ce/clr got %b expected 0001", name,
                     {bigIf.busy, bigIf.done, bigIf.cntCe, bigIf.cntClr});
        end
    endtask

    // Reset values on both instances while CLR is held
    task automatic test_reset();
        clr = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bigIf.cntCe, bigIf.cntClr, bigIf.busy, bigIf.done, bigIf.err} !== 5'b01000 ||
            bigIf.sel !== 4'd0 || bigIf.response !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_big: ce/clr/busy/done/err %b sel %h resp %h expected 01000 0 0000",
                     {bigIf.cntCe, bigIf.cntClr, bigIf.busy, bigIf.done, bigIf.err}, bigIf.sel, bigIf.response);
        end
        checks++;
        if ({smallIf.cntCe, smallIf.cntClr, smallIf.busy, smallIf.done, smallIf.err} !== 5'b01000 ||
            smallIf.sel !== 4'd0 || smallIf.response !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_small: ce/clr/busy/done/err %b sel %h resp %h expected 01000 0 0000",
                     {smallIf.cntCe, smallIf.cntClr, smallIf.busy, smallIf.done, smallIf.err}, smallIf.sel, smallIf.response);
        end
        clr = 1'b0;
        @(negedge clk);
    endtask

    // A wins on odd indices, B wins on even indices
    task automatic test_full_run();
        for (int i = 0; i < 16; i++) begin
            nCount[i]  = $urandom_range(1, 12);
            finMode[i] = $urandom_range(0, 2);
            if (i % 2 == 1) begin
                aVals[i] = 16'h8000 + 16'($urandom_range(1, 1000));
                bVals[i] = 16'h8000 - 16'($urandom_range(1, 1000));
            end else begin
                aVals[i] = 16'h2000 + 16'($urandom_range(0, 1000));
                bVals[i] = 16'h3000 + 16'($urandom_range(0, 1000));
            end
        end
        injectStart = 1'b0;
        applyStimulus(BIG_BITS);
        checkOutput("full_run", BIG_BITS);
        checks++;
        if (bigIf.response !== 16'hAAAA) begin
            errors++;
            $display("[TB] FAIL full_run_aaaa: got %h expected aaaa", bigIf.response);
        end
    endtask

    // Several runs with random counts, finish flags and run lengths
    task automatic test_random_runs();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                nCount[i]  = $urandom_range(1, 15);
                finMode[i] = $urandom_range(0, 2);
                aVals[i]   = 16'($urandom);
                bVals[i]   = ($urandom_range(0, 3) == 0) ? aVals[i] : 16'($urandom);
            end
            injectStart = 1'b0;
            applyStimulus(BIG_BITS);
            checkOutput($sformatf("random_run%0d", r), BIG_BITS);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    // Simultaneous finish flags with ties on even bits
    task automatic test_tie_simultaneous();
        for (int i = 0; i < 16; i++) begin
            nCount[i]  = $urandom_range(1, 8);
            finMode[i] = 2;
            if (i % 2 == 0) begin
                aVals[i] = 16'h4000;
                bVals[i] = 16'h4000;
            end else begin
                aVals[i] = 16'($urandom);
                bVals[i] = 16'($urandom);
            end
        end
        injectStart = 1'b0;
        applyStimulus(BIG_BITS);
        checkOutput("tie_simultaneous", BIG_BITS);
    endtask

    // START pulsed during SETTLE of the first bit must not disturb the run
    task automatic test_start_while_busy();
        for (int i = 0; i < 16; i++) begin
            nCount[i]  = $urandom_range(1, 10);
            finMode[i] = $urandom_range(0, 2);
            aVals[i]   = 16'($urandom);
            bVals[i]   = 16'($urandom);
        end
        injectStart = 1'b1;
        applyStimulus(BIG_BITS);
        injectStart = 1'b0;
        checkOutput("start_while_busy", BIG_BITS);
    endtask

    // One-bit instance: FIN_A after 10 COUNT cycles, A = 0x4000, B = 0x3FF0
    task automatic test_single_bit();
        int cyc;
        int cnt;
        int doneCyc;
        bit finPending;
        cnt        = 0;
        doneCyc    = -1;
        finPending = 1'b0;
        smallIf.start = 1'b1;
        @(negedge clk);
        smallIf.start = 1'b0;
        cyc = 1;
        while (cyc < 200) begin
            if (finPending) begin
                smallIf.finA = 1'b0;
                finPending   = 1'b0;
            end
            if (smallIf.done && doneCyc < 0) doneCyc = cyc;
            if (smallIf.cntCe) begin
                cnt++;
                if (cnt == 10) begin
                    smallIf.cntA = 16'h4000;
                    smallIf.cntB = 16'h3FF0;
                    smallIf.finA = 1'b1;
                    finPending   = 1'b1;
                end
            end
            if (doneCyc >= 0 && cyc >= doneCyc + 2) break;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (doneCyc != 16) begin
            errors++;
            $display("[TB] FAIL single_bit_done_cycle: got %0d expected 16", doneCyc);
        end
        checks++;
        if (smallIf.response !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL single_bit_response: got %h expected 0001", smallIf.response);
        end
        checks++;
        if (smallIf.busy !== 1'b0 || smallIf.cntClr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_bit_idle: busy %b clr %b expected 0 1", smallIf.busy, smallIf.cntClr);
        end
    endtask

    // CLR pulsed in COUNT of the second bit after the first bit scored a 1
    task automatic test_reset_mid_count();
        int cnt;
        cnt = 0;
        bigIf.cntA  = 16'h5000;
        bigIf.cntB  = 16'h1000;
        bigIf.start = 1'b1;
        @(negedge clk);
        bigIf.start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (bigIf.finA) bigIf.finA = 1'b0;
            if (bigIf.cntCe && bigIf.sel == 4'd0) begin
                cnt++;
                if (cnt == 3) bigIf.finA = 1'b1;
            end
            if (bigIf.cntCe && bigIf.sel == 4'd1) begin
                cnt++;
                if (cnt == 23) break;
            end
            @(negedge clk);
        end
        checks++;
        if (bigIf.cntCe !== 1'b1 || bigIf.sel !== 4'd1 || bigIf.response !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL mid_count_precondition: ce %b sel %h resp %h expected 1 1 0001",
                     bigIf.cntCe, bigIf.sel, bigIf.response);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if ({bigIf.cntCe, bigIf.cntClr, bigIf.busy, bigIf.done} !== 4'b0100 ||
            bigIf.sel !== 4'd0 || bigIf.response !== 16'd0) begin
            errors++;
            $display("[TB] FAIL mid_count_reset: ce/clr/busy/done %b sel %h resp %h expected 0100 0 0000",
                     {bigIf.cntCe, bigIf.cntClr, bigIf.busy, bigIf.done}, bigIf.sel, bigIf.response);
        end
        @(negedge clk);
    endtask

`ifdef RO_PUF_TIMEOUT_EN
    // No finish flag: watchdog must end COUNT after 64 cycles, zero the bit and raise ERR
    task automatic test_timeout();
        int ceCycles;
        ceCycles = 0;
        bigIf.finA  = 1'b0;
        bigIf.finB  = 1'b0;
        bigIf.cntA  = 16'h5000;
        bigIf.cntB  = 16'h1000;
        bigIf.start = 1'b1;
        @(negedge clk);
        bigIf.start = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (bigIf.cntCe) ceCycles++;
            else if (ceCycles > 0) break;
            @(negedge clk);
        end
        checks++;
        if (ceCycles != 64) begin
            errors++;
            $display("[TB] FAIL timeout_count_cycles: got %0d expected 64", ceCycles);
        end
        checks++;
        if (bigIf.err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_err_at_capture: got %b expected 1", bigIf.err);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bigIf.response[0] !== 1'b0 || bigIf.err !== 1'b1 || bigIf.sel !== 4'd1) begin
            errors++;
            $display("[TB] FAIL timeout_bit: resp0 %b err %b sel %h expected 0 1 1",
                     bigIf.response[0], bigIf.err, bigIf.sel);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (bigIf.err !== 1'b0 || bigIf.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_clr: err %b busy %b expected 0 0", bigIf.err, bigIf.busy);
        end
        @(negedge clk);
    endtask
`else
    // No finish flag and no watchdog: COUNT must persist with ERR low
    task automatic test_timeout();
        int ceCycles;
        ceCycles = 0;
        bigIf.finA  = 1'b0;
        bigIf.finB  = 1'b0;
        bigIf.start = 1'b1;
        @(negedge clk);
        bigIf.start = 1'b0;
        repeat (1 + BIG_SETTLE) @(negedge clk);
        for (int c = 0; c < 200; c++) begin
            if (bigIf.cntCe) ceCycles++;
            @(negedge clk);
        end
        checks++;
        if (ceCycles != 200) begin
            errors++;
            $display("[TB] FAIL no_timeout_count: ce high %0d of 200 cycles", ceCycles);
        end
        checks++;
        if (bigIf.err !== 1'b0 || bigIf.busy !== 1'b1 || bigIf.sel !== 4'd0) begin
            errors++;
            $display("[TB] FAIL no_timeout_state: err %b busy %b sel %h expected 0 1 0",
                     bigIf.err, bigIf.busy, bigIf.sel);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (bigIf.busy !== 1'b0 || bigIf.cntCe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_timeout_clr: busy %b ce %b expected 0 0", bigIf.busy, bigIf.cntCe);
        end
        @(negedge clk);
    endtask
`endif

    // Test sequence
    initial begin
        checks        = 0;
        errors        = 0;
        injectStart   = 1'b0;
        clr           = 1'b1;
        bigIf.start   = 1'b0;
        bigIf.cntA    = 16'd0;
        bigIf.cntB    = 16'd0;
        bigIf.finA    = 1'b0;
        bigIf.finB    = 1'b0;
        smallIf.start = 1'b0;
        smallIf.cntA  = 16'd0;
        smallIf.cntB  = 16'd0;
        smallIf.finA  = 1'b0;
        smallIf.finB  = 1'b0;

        test_reset();
        test_single_bit();
        test_full_run();
        test_random_runs();
        test_tie_simultaneous();
        test_start_while_busy();
        test_reset_mid_count();
        test_timeout();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ro_puf_compare_ctrl.md
RO_PUF_COMPARE_CTRL -- requirements
Module: ro_puf_compare_ctrl

Interface
REQ-001 Parameter NUM_BITS, default 16: response bits generated per run, legal range 1..16.
REQ-002 Parameter SETTLE_CYCLES, default 4: idle cycles after SEL changes before counting starts, legal range 1..255.
REQ-003 Parameter TIMEOUT_CYCLES, default 1048576: COUNT-state watchdog limit; used only when RO_PUF_TIMEOUT_EN is defined.
REQ-004 CLK  in  1  the single clock; all state changes on its rising edge.
REQ-005 CLR  in  1  reset, synchronous, active-high.
REQ-006 START  in  1  single-cycle request to begin a run.
REQ-007 CNT_A  in  16  count value from counter A.
REQ-008 CNT_B  in  16  count value from counter B.
REQ-009 FIN_A  in  1  finished flag from counter A.
REQ-010 FIN_B  in  1  finished flag from counter B.
REQ-011 CNT_CE  out  1  count enable, driven to both counters.
REQ-012 CNT_CLR  out  1  synchronous clear, driven to both counters.
REQ-013 SEL  out  4  challenge index driven to the ring-oscillator pair mux.
REQ-014 BUSY  out  1  high whenever the FSM is not in IDLE.
REQ-015 DONE  out  1  one-cycle pulse marking run completion.
REQ-016 RESPONSE  out  16  response word; bit i holds the result for SEL=i.
REQ-017 ERR  out  1  sticky timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, SETTLE, COUNT, CAPTURE, COMPARE and FINISH.
REQ-019 IDLE: CNT_CLR=1 and CNT_CE=0. START=1 SHALL move to CLEAR and, on the same edge, zero SEL, RESPONSE and ERR.
REQ-020 CLEAR: exactly 1 cycle with CNT_CLR=1 and CNT_CE=0, then go to SETTLE.
REQ-021 SETTLE: exactly SETTLE_CYCLES cycles with CNT_CLR=0 and CNT_CE=0, then go to COUNT.
REQ-022 COUNT: CNT_CE=1 and CNT_CLR=0; FIN_A or FIN_B sampled high SHALL move to CAPTURE, and CNT_CE SHALL be 0 in the following cycle.
REQ-023 CAPTURE: 1 cycle with CNT_CE=0; CNT_A and CNT_B are registered at the end of this cycle, after the counters have frozen.
REQ-024 COMPARE: RESPONSE[SEL] SHALL be written with 1 if captured A > captured B, else 0. A tie gives 0.
REQ-025 COMPARE, SEL = NUM_BITS-1: next state is FINISH.
REQ-026 COMPARE, SEL < NUM_BITS-1: SEL increments and next state is CLEAR.
REQ-027 FINISH: DONE=1 for exactly 1 cycle, then go to IDLE. RESPONSE and ERR hold until the next accepted START.
REQ-028 START outside IDLE SHALL be ignored.
REQ-029 FIN_A and FIN_B high in the same cycle SHALL be treated as a normal finish; the bit is decided by the captured counts.
REQ-030 Per-bit latency SHALL be 1 + SETTLE_CYCLES + (COUNT cycles) + 2.
REQ-031 RESPONSE bits at index NUM_BITS or above SHALL remain 0.

Reset
REQ-032 CLR=1 SHALL force IDLE on the next edge from any state, including mid-COUNT.
REQ-033 Reset output values: CNT_CE=0, CNT_CLR=1, SEL=0, BUSY=0, DONE=0, RESPONSE=0, ERR=0.
REQ-034 CLR SHALL take priority over START in the same cycle.

Configuration
REQ-035 The feature macro SHALL be RO_PUF_TIMEOUT_EN.
REQ-036 RO_PUF_TIMEOUT_EN defined: a cycle counter runs in COUNT. If neither FIN flag has risen after TIMEOUT_CYCLES cycles, the FSM goes to CAPTURE, RESPONSE[SEL] is forced to 0 and ERR is set to 1. ERR stays set until the next START or CLR.
REQ-037 RO_PUF_TIMEOUT_EN undefined: no watchdog logic is built, ERR is tied to 0, and COUNT waits indefinitely.

Verification
REQ-038 Reset mid-run: CLR pulsed during COUNT -> next cycle is IDLE with CNT_CE=0, CNT_CLR=1, SEL=0, RESPONSE=0 and BUSY=0.
REQ-039 Single bit: NUM_BITS=1, SETTLE_CYCLES=2, FIN_A after 10 COUNT cycles with CNT_A=0x4000 and CNT_B=0x3FF0 -> RESPONSE=0x0001, with DONE pulsed exactly 16 cycles after START.
REQ-040 Full run: NUM_BITS=16, A wins on odd SEL and B wins on even SEL -> RESPONSE=0xAAAA, with SEL stepping 0..15 in order.
REQ-041 Tie and simultaneous finish: FIN_A=FIN_B=1 in the same cycle with CNT_A=CNT_B=0x4000 -> bit is 0 and no error is raised.
REQ-042 START while BUSY: START=1 during SETTLE -> ignored; SEL and RESPONSE are unaffected.
REQ-043 Timeout: RO_PUF_TIMEOUT_EN defined, TIMEOUT_CYCLES=64, FIN flags held at 0 -> CAPTURE entered after 64 COUNT cycles with ERR=1 and RESPONSE[0]=0. Macro undefined -> FSM remains in COUNT and ERR=0.
